// File: rtl/i2s_capture_sequencer_if.sv
// Control/data bundle between the register front end, the I2S receiver and the
// sample FIFO on one side and the capture sequencer on the other.
interface i2s_capture_sequencer_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 12
);
    logic             start;
    logic             stop;
    logic             cont;
    logic [1:0]       ch_sel;
    logic [CNT_W-1:0] frame_len;
    logic             smp_valid;
    logic             smp_ws;
    logic [DW-1:0]    smp_data;
    logic             i2s_en;
    logic             fifo_full;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_wdata;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [7:0]       overrun_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic             irq;

    // Environment side: registers, receiver and FIFO
    modport master (
        output start, stop, cont, ch_sel, frame_len, smp_valid, smp_ws, smp_data, fifo_full,
        input  i2s_en, fifo_wr, fifo_wdata, busy, done, overrun, overrun_cnt, sample_cnt, irq
    );

    // Sequencer side
    modport slave (
        input  start, stop, cont, ch_sel, frame_len, smp_valid, smp_ws, smp_data, fifo_full,
        output i2s_en, fifo_wr, fifo_wdata, busy, done, overrun, overrun_cnt, sample_cnt, irq
    );
endinterface

// File: rtl/i2s_capture_sequencer.sv
// Sequences an I2S receiver and its sample FIFO: enable, discard warm-up words,
// align to the frame's first channel, push FRAME_LEN selected samples, interrupt.
module i2s_capture_sequencer #(
    parameter int unsigned DW     = 32,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned WARMUP = 2
) (
    input logic                     HCLK,
    input logic                     HRESETn,
    i2s_capture_sequencer_if.slave  seq_io
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWarm    = 2'd1;
    localparam logic [1:0] StAlign   = 2'd2;
    localparam logic [1:0] StCapture = 2'd3;

    localparam logic [CNT_W-1:0] WarmLast   = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [1:0]       FirstState = (WARMUP == 0) ? StAlign : StWarm;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       chsel_q, chsel_d;
    logic             cont_q, cont_d;
    logic [CNT_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       ovr_cnt_q, ovr_cnt_d;
    logic             wr_q, wr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             irq_q, irq_d;

    logic             take;
    logic             sel;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] cnt_inc;

    // Next-state: FSM, config latch, frame counting and overrun bookkeeping
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chsel_d   = chsel_q;
        cont_d    = cont_q;
        warm_d    = warm_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        ovr_cnt_d = ovr_cnt_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        irq_d     = 1'b0;
        take      = 1'b0;
        // Stereo (10/11) takes both channels; mono takes the matching one
        sel       = chsel_q[1] | (seq_io.smp_ws == chsel_q[0]);
        // In continuous mode a completed frame restarts counting from zero
        base      = (cnt_q == len_q) ? '0 : cnt_q;
        cnt_inc   = base + CNT_W'(1);

        if (state_q == StCapture && cnt_q == len_q) begin
            cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (seq_io.start && !seq_io.stop && seq_io.frame_len != '0) begin
                    len_d     = seq_io.frame_len;
                    chsel_d   = seq_io.ch_sel;
                    cont_d    = seq_io.cont;
                    warm_d    = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    ovr_d     = 1'b0;
                    ovr_cnt_d = '0;
                    state_d   = FirstState;
                end
            end
            StWarm: begin
                if (seq_io.stop) begin
                    state_d = StIdle;
                end else if (seq_io.smp_valid) begin
                    if (warm_q == WarmLast) begin
                        state_d = StAlign;
                    end else begin
                        warm_d = warm_q + CNT_W'(1);
                    end
                end
            end
            StAlign: begin
                if (seq_io.stop) begin
                    state_d = StIdle;
                end else if (seq_io.smp_valid && seq_io.smp_ws == (chsel_q == 2'b01)) begin
                    take    = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (seq_io.stop) begin
                    state_d = StIdle;
                end else if (seq_io.smp_valid && sel) begin
                    take = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            if (seq_io.fifo_full) begin
                ovr_d = 1'b1;
                if (ovr_cnt_q != 8'hFF) begin
                    ovr_cnt_d = ovr_cnt_q + 8'd1;
                end
            end else begin
                wr_d    = 1'b1;
                wdata_d = seq_io.smp_data;
                cnt_d   = cnt_inc;
                if (cnt_inc == len_q) begin
                    done_d = 1'b1;
                    irq_d  = 1'b1;
                    if (!cont_q) begin
                        state_d = StIdle;
                    end
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            chsel_q   <= '0;
            cont_q    <= 1'b0;
            warm_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            chsel_q   <= chsel_d;
            cont_q    <= cont_d;
            warm_q    <= warm_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            irq_q     <= irq_d;
        end
    end

    assign seq_io.i2s_en      = (state_q != StIdle);
    assign seq_io.busy        = (state_q != StIdle);
    assign seq_io.fifo_wr     = wr_q;
    assign seq_io.fifo_wdata  = wdata_q;
    assign seq_io.done        = done_q;
    assign seq_io.overrun     = ovr_q;
    assign seq_io.overrun_cnt = ovr_cnt_q;
    assign seq_io.sample_cnt  = cnt_q;
    assign seq_io.irq         = irq_q;
endmodule

// File: tb/tb_i2s_capture_sequencer.sv
// Bench for i2s_capture_sequencer: randomized receiver streams checked against a
// stream-level model of which words should reach the FIFO and where frames end.
module tb_i2s_capture_sequencer;
    localparam int WARMUP = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    i2s_capture_sequencer_if #(.DW(32), .CNT_W(12)) bus ();

    i2s_capture_sequencer #(.DW(32), .CNT_W(12), .WARMUP(WARMUP)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .seq_io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus stream and model results
    bit          stim_ws[$];
    bit          stim_full[$];
    logic [31:0] stim_data[$];
    logic [31:0] exp_wr[$];
    int          exp_irq_at[$];
    int          exp_drops;
    bit          exp_ended;

    // Observed FIFO writes and interrupts
    logic [31:0] got_wr[$];
    int          got_irq_at[$];
    int          got_irq_cnt[$];
    bit          got_irq_en[$];
    int          orphan_irq;

    // Record every write and interrupt mid-cycle
    always @(negedge clk) begin
        if (bus.fifo_wr === 1'b1) got_wr.push_back(bus.fifo_wdata);
        if (bus.irq === 1'b1) begin
            got_irq_at.push_back(got_wr.size());
            got_irq_cnt.push_back(int'(bus.sample_cnt));
            got_irq_en.push_back(bus.i2s_en);
            if (bus.fifo_wr !== 1'b1) orphan_irq++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        stim_ws.delete(); stim_full.delete(); stim_data.delete();
        got_wr.delete(); got_irq_at.delete(); got_irq_cnt.delete(); got_irq_en.delete();
        orphan_irq = 0;
    endtask

    task automatic push(input bit ws, input logic [31:0] d, input bit full);
        stim_ws.push_back(ws);
        stim_data.push_back(d);
        stim_full.push_back(full);
    endtask

    // Which words reach the FIFO, computed from the stream rules alone
    task automatic model(input int len, input int mode, input bit c);
        int warm;
        int inframe;
        bit aligned;
        bit want;
        exp_wr.delete(); exp_irq_at.delete();
        exp_drops = 0; exp_ended = 0;
        warm = WARMUP; aligned = 0; inframe = 0;
        want = (mode == 1);
        for (int i = 0; i < stim_ws.size(); i++) begin
            if (exp_ended) break;
            if (warm > 0) begin warm--; continue; end
            if (!aligned && stim_ws[i] != want) continue;
            aligned = 1;
            if (mode < 2 && stim_ws[i] != want) continue;
            if (stim_full[i]) begin exp_drops++; continue; end
            exp_wr.push_back(stim_data[i]);
            inframe++;
            if (inframe == len) begin
                exp_irq_at.push_back(exp_wr.size());
                inframe = 0;
                if (!c) exp_ended = 1;
            end
        end
    endtask

    task automatic arm(input int len, input int mode, input bit c);
        bus.frame_len = 12'(len);
        bus.ch_sel    = 2'(mode);
        bus.cont      = c;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic word(input bit ws, input logic [31:0] d, input bit full);
        bus.smp_valid = 1'b1;
        bus.smp_ws    = ws;
        bus.smp_data  = d;
        bus.fifo_full = full;
        tick();
        bus.smp_valid = 1'b0;
        bus.fifo_full = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic play(input int from, input int upto);
        for (int i = from; i < upto; i++) word(stim_ws[i], stim_data[i], stim_full[i]);
    endtask

    task automatic stop_pulse();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.i2s_en !== 1'b0) begin n_fail++; $display("FAIL reset_i2s_en got=%b exp=0", bus.i2s_en); end
        n_checks++; if ({bus.fifo_wr, bus.irq, bus.done, bus.overrun} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.fifo_wr, bus.irq, bus.done, bus.overrun});
        end
        n_checks++; if ({bus.overrun_cnt, bus.sample_cnt, bus.fifo_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_counts ovr=%0d cnt=%0d wdata=%h exp=0", bus.overrun_cnt, bus.sample_cnt, bus.fifo_wdata);
        end
    endtask

    // Compare observed writes/irqs to the model
    task automatic compare_stream(input string name, input bit cont_mode);
        n_checks++; if (got_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL %s_wr_count got=%0d exp=%0d", name, got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            n_checks++;
            if (i >= got_wr.size() || got_wr[i] !== exp_wr[i]) begin
                n_fail++;
                $display("FAIL %s_wr_data[%0d] got=%h exp=%h", name, i,
                         (i < got_wr.size()) ? got_wr[i] : 32'hx, exp_wr[i]);
            end
        end
        n_checks++; if (got_irq_at != exp_irq_at) begin
            n_fail++; $display("FAIL %s_irq_pos got=%p exp=%p", name, got_irq_at, exp_irq_at);
        end
        for (int i = 0; i < got_irq_en.size(); i++) begin
            n_checks++; if (got_irq_en[i] !== cont_mode) begin
                n_fail++; $display("FAIL %s_i2s_en_at_irq[%0d] got=%b exp=%b", name, i, got_irq_en[i], cont_mode);
            end
        end
        n_checks++; if (orphan_irq != 0) begin
            n_fail++; $display("FAIL %s_irq_without_wr got=%0d exp=0", name, orphan_irq);
        end
    endtask

    task automatic test_mono_left();
        clear_all();
        push(0, 100, 0); push(1, 101, 0);
        push(1, 2, 0);
        for (int i = 3; i < 15; i++) push(bit'((i + 1) % 2), 32'(i), 0);
        model(4, 0, 0);
        arm(4, 0, 0);
        play(0, stim_ws.size());
        repeat (2) tick();
        compare_stream("mono", 0);
        n_checks++; if (got_wr.size() > 0 && got_wr[0] !== 32'd3) begin
            n_fail++; $display("FAIL mono_first_left got=%0d exp=3", got_wr[0]);
        end
        n_checks++; if ({bus.done, bus.busy, bus.i2s_en} !== 3'b100) begin
            n_fail++; $display("FAIL mono_end_flags done/busy/en got=%b exp=100", {bus.done, bus.busy, bus.i2s_en});
        end
    endtask

    task automatic test_stereo();
        clear_all();
        push(bit'($urandom_range(0, 1)), $urandom, 0);
        push(bit'($urandom_range(0, 1)), $urandom, 0);
        push(1, $urandom, 0);
        for (int i = 0; i < 10; i++) push(bit'(i % 2), $urandom, 0);
        model(6, 2, 0);
        arm(6, 2, 0);
        play(0, stim_ws.size());
        repeat (2) tick();
        compare_stream("stereo", 0);
        n_checks++; if (got_irq_cnt.size() != 1 || got_irq_cnt[0] != 6) begin
            n_fail++; $display("FAIL stereo_cnt_at_irq got=%p exp=6", got_irq_cnt);
        end
    endtask

    task automatic test_overrun();
        int lefts;
        clear_all();
        push(0, $urandom, 0); push(0, $urandom, 0);
        lefts = 0;
        for (int i = 0; i < 20; i++) begin
            bit ws = bit'(i % 2);
            bit full = 0;
            if (ws == 0) begin
                full = (lefts >= 2 && lefts < 5);
                lefts++;
            end else begin
                full = bit'($urandom_range(0, 1));
            end
            push(ws, $urandom, full);
        end
        model(5, 0, 0);
        arm(5, 0, 0);
        play(0, stim_ws.size());
        repeat (2) tick();
        compare_stream("ovr", 0);
        n_checks++; if (bus.overrun !== 1'b1 || int'(bus.overrun_cnt) != exp_drops) begin
            n_fail++; $display("FAIL ovr_count got=%b/%0d exp=1/%0d", bus.overrun, bus.overrun_cnt, exp_drops);
        end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ovr_done got=%b exp=1", bus.done); end

        // Saturation run
        clear_all();
        push(0, $urandom, 0); push(1, $urandom, 0);
        for (int i = 0; i < 300; i++) push(bit'(i % 2), $urandom, 1);
        for (int i = 0; i < 5; i++) push(bit'(i % 2), $urandom, 0);
        model(5, 2, 0);
        arm(5, 2, 0);
        n_checks++; if ({bus.overrun, bus.overrun_cnt, bus.done} !== '0) begin
            n_fail++; $display("FAIL sat_cleared_at_start got=%b/%0d/%b exp=0", bus.overrun, bus.overrun_cnt, bus.done);
        end
        play(0, stim_ws.size());
        repeat (2) tick();
        compare_stream("sat", 0);
        n_checks++; if (int'(bus.overrun_cnt) != ((exp_drops > 255) ? 255 : exp_drops)) begin
            n_fail++; $display("FAIL sat_ovr_cnt got=%0d exp=255", bus.overrun_cnt);
        end
    endtask

    task automatic test_continuous();
        clear_all();
        push(0, $urandom, 0); push(1, $urandom, 0);
        for (int i = 0; i < 18; i++) push(bit'(i % 2), $urandom, 0);
        model(3, 1, 1);
        arm(3, 1, 1);
        play(0, 10);
        // start while busy must not disturb the latched frame length
        bus.frame_len = 12'd1; bus.ch_sel = 2'b00; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        play(10, stim_ws.size());
        repeat (3) tick();
        compare_stream("cont", 1);
        n_checks++; if (got_irq_cnt.size() != 3 || got_irq_cnt[0] != 3 || got_irq_cnt[2] != 3) begin
            n_fail++; $display("FAIL cont_cnt_at_irq got=%p exp=3,3,3", got_irq_cnt);
        end
        n_checks++; if ({bus.busy, bus.i2s_en, bus.done} !== 3'b111 || bus.sample_cnt !== '0) begin
            n_fail++; $display("FAIL cont_running busy/en/done got=%b cnt=%0d exp=111 cnt=0",
                               {bus.busy, bus.i2s_en, bus.done}, bus.sample_cnt);
        end
        stop_pulse();
        n_checks++; if ({bus.busy, bus.i2s_en, bus.done} !== 3'b001) begin
            n_fail++; $display("FAIL cont_stop busy/en/done got=%b exp=001", {bus.busy, bus.i2s_en, bus.done});
        end
    endtask

    task automatic test_abort();
        clear_all();
        arm(8, 0, 0);
        word(0, 32'h10, 0); word(0, 32'h11, 0);
        word(0, 32'hA0, 0); word(1, 32'hA1, 0); word(0, 32'hA2, 0);
        tick();
        bus.stop = 1'b1; bus.start = 1'b1; bus.frame_len = 12'd8;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        n_checks++; if ({bus.busy, bus.i2s_en, bus.done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle busy/en/done got=%b exp=000", {bus.busy, bus.i2s_en, bus.done});
        end
        n_checks++; if (bus.sample_cnt !== 12'd2) begin
            n_fail++; $display("FAIL abort_sample_cnt got=%0d exp=2", bus.sample_cnt);
        end
        for (int i = 0; i < 6; i++) word(bit'(i % 2), 32'hB0 + 32'(i), 0);
        tick();
        n_checks++; if (got_wr.size() != 2) begin
            n_fail++; $display("FAIL abort_no_more_writes got=%0d exp=2", got_wr.size());
        end
        arm(0, 0, 0);
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_len_start busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_capture();
        clear_all();
        arm(8, 2, 0);
        word(0, 32'h20, 0); word(1, 32'h21, 0);
        word(0, 32'hC0, 0); word(1, 32'hC1, 0);
        bus.smp_valid = 1'b1; bus.smp_ws = 1'b0; bus.smp_data = 32'hC2; rst_n = 1'b0;
        tick();
        bus.smp_valid = 1'b0;
        n_checks++; if ({bus.fifo_wr, bus.irq, bus.busy, bus.i2s_en, bus.done, bus.overrun} !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid_flags got=%b exp=000000",
                               {bus.fifo_wr, bus.irq, bus.busy, bus.i2s_en, bus.done, bus.overrun});
        end
        n_checks++; if ({bus.overrun_cnt, bus.sample_cnt, bus.fifo_wdata} !== '0) begin
            n_fail++; $display("FAIL rst_mid_counts ovr=%0d cnt=%0d wdata=%h exp=0",
                               bus.overrun_cnt, bus.sample_cnt, bus.fifo_wdata);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if (got_wr.size() != 2) begin
            n_fail++; $display("FAIL rst_mid_writes got=%0d exp=2", got_wr.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int mode = $urandom_range(0, 3);
            int len  = $urandom_range(1, 6);
            clear_all();
            for (int i = 0; i < 40; i++) push(bit'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 4) == 0));
            model(len, mode, 0);
            arm(len, mode, 0);
            play(0, stim_ws.size());
            repeat (2) tick();
            compare_stream("rand", 0);
            n_checks++; if (int'(bus.overrun_cnt) != exp_drops || bus.done !== exp_ended) begin
                n_fail++; $display("FAIL rand_status ovr=%0d done=%b exp ovr=%0d done=%b",
                                   bus.overrun_cnt, bus.done, exp_drops, exp_ended);
            end
            if (bus.busy) stop_pulse();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; orphan_irq = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0; bus.ch_sel = 2'b00;
        bus.frame_len = '0; bus.smp_valid = 1'b0; bus.smp_ws = 1'b0; bus.smp_data = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_mono_left();
        test_stereo();
        test_overrun();
        test_continuous();
        test_abort();
        test_reset_mid_capture();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_capture_sequencer.md
Name: i2s_capture_sequencer

Overview:
Controller that sequences an I2S receiver core and the sample FIFO behind it. Software arms a capture window through register-driven inputs. The block then:
- enables the receiver and discards warm-up samples;
- aligns to a left-channel word;
- pushes exactly FRAME_LEN selected-channel samples into the FIFO;
- raises a one-cycle interrupt at frame end.
It sits between the AHB-Lite register front end and the i2s/aucohl_fifo pair, replacing ad-hoc enable/write gating.

Parameters:
DW, 32, sample and FIFO data width
CNT_W, 12, width of frame-length and sample counters
WARMUP, 2, number of receiver sample events discarded after each enable

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESETn  input  1  synchronous active-low reset
start  input  1  one-cycle pulse: arm a capture
stop  input  1  one-cycle pulse: abort capture
cont  input  1  1 = continuous frames, 0 = single frame
ch_sel  input  2  00 left only, 01 right only, 10 stereo (L,R pairs), 11 treated as 10
frame_len  input  CNT_W  samples per frame; latched at start
smp_valid  input  1  one-cycle pulse from receiver: new word ready
smp_ws  input  1  channel of the word: 0 left, 1 right
smp_data  input  DW  receiver word
i2s_en  output  1  receiver enable
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_wdata  output  DW  FIFO write data
busy  output  1  high in any state other than IDLE
done  output  1  sticky frame-complete flag
overrun  output  1  sticky: a sample was dropped on full FIFO
overrun_cnt  output  8  dropped-sample count, saturating at 255
sample_cnt  output  CNT_W  samples written in the current frame
irq  output  1  one-cycle pulse at each frame completion

Behaviour:
- Reset: all outputs 0; state IDLE; internal latched frame_len, warm-up counter and cont latch cleared. Reset mid-capture aborts immediately and drops any pending write.
- States: IDLE, WARM, ALIGN, CAPTURE.
- IDLE:
  - start with frame_len != 0: latch frame_len/ch_sel/cont; clear done, overrun, overrun_cnt, sample_cnt; go to WARM.
  - i2s_en rises the cycle after start is sampled.
  - start with frame_len == 0 is ignored.
- WARM: i2s_en=1; count smp_valid events; the WARMUP-th event moves to ALIGN. With WARMUP=0, go directly to ALIGN. Warm-up words are never written.
- ALIGN:
  - Wait for smp_valid with smp_ws==0 for modes 00/10, or smp_ws==1 for mode 01.
  - That same word is the first captured sample and is handled as in CAPTURE in that cycle; go to CAPTURE.
- CAPTURE:
  - A word is selected if its channel matches ch_sel. In stereo, both channels are selected.
  - Selected word with fifo_full=0: fifo_wr=1 and fifo_wdata=smp_data exactly one cycle later (registered); sample_cnt increments.
  - Selected word with fifo_full=1 (sampled in the smp_valid cycle): word dropped; overrun=1; overrun_cnt++ saturating at 255; sample_cnt unchanged.
  - Unselected words are ignored.
- Frame end: the write that makes sample_cnt == latched frame_len also sets done=1 and pulses irq in the same cycle as that fifo_wr.
  - cont=0: go to IDLE; i2s_en falls the same cycle.
  - cont=1: stay in CAPTURE; sample_cnt reloads to 0 on the next cycle; no realignment. irq pulses at every frame end.
- sample_cnt wraps never. Frame end occurs before overflow, since frame_len <= 2^CNT_W - 1.
- stop, in any non-IDLE state: go to IDLE next cycle; i2s_en=0; done untouched; a write registered in the stop cycle still completes.
- stop and start in the same cycle: stop wins; start is ignored.
- start while busy: ignored; latched config unchanged.
- fifo_wr is never asserted while fifo_full was high at the triggering smp_valid. At most one fifo_wr per smp_valid.

Test Plan:
- Mono left, WARMUP=2, frame_len=4, cont=0:
  - Stimulus: 2 warm-up words, then a right word, then alternating L/R with data=index.
  - Required: first write is the first left word. Exactly 4 writes, of left words only. irq is a single pulse with the 4th fifo_wr. done=1, busy=0, i2s_en=0 next cycle.
- Stereo, frame_len=6, first post-warm-up word is right:
  - Required: that right word is skipped. Writes are L,R,L,R,L,R in order. sample_cnt reads 6 at irq.
- Overrun: fifo_full held high for 3 selected words mid-frame, frame_len=5.
  - Required: overrun=1 and overrun_cnt=3. The frame still completes after 5 actual writes.
  - Second run, with 300 drops: overrun_cnt saturates at 255.
- Continuous, frame_len=3, 9 selected words:
  - Required: irq pulses 3 times, 3 writes apart. busy stays 1; i2s_en stays 1.
- Abort: stop 2 writes into a frame_len=8 capture, issued in the same cycle as a start pulse.
  - Required: IDLE next cycle with i2s_en=0. done=0; sample_cnt holds 2; no further writes.
  - A later start with frame_len=0 leaves busy=0.
- Reset mid-CAPTURE, asserted in a smp_valid cycle:
  - Required: no fifo_wr follows. All outputs 0 next edge.
